// File: rtl/bus_ram.sv
// Single-port word RAM behind a valid/ready memory bus with out-of-range error reporting.
// Optional wait states are enabled by defining BUS_RAM_WAIT_EN (count set by WAIT_CYCLES).
module bus_ram #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    // 33-bit upper bound so a window ending at the top of the address space cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

`ifdef BUS_RAM_WAIT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd2
    } state_t;
`endif

    state_t state;

`ifdef BUS_RAM_WAIT_EN
    logic [3:0] wait_cnt;
`endif

    logic [31:0] ram [DEPTH] = '{default: 32'h0};

    logic                  addr_in_range;
    logic [ADDR_WIDTH-1:0] addr_idx;

    logic                  req_in_range;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [3:0]            req_wstrb;
    logic [31:0]           req_wdata;

    // Aligned BASE_ADDR and LIMIT make the low address bits irrelevant to both decode results.
    assign addr_in_range = ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, mem_addr} < LIMIT);
    assign addr_idx      = ADDR_WIDTH'((mem_addr - BASE_ADDR) >> 2);

    assign mem_ready = (state == RESP) && mem_valid;
    assign err       = mem_ready && !req_in_range;

    // Request capture: only the IDLE acceptance cycle samples the bus.
    always_ff @(posedge clk) begin
        if (state == IDLE && mem_valid) begin
            req_in_range <= addr_in_range;
            req_idx      <= addr_idx;
            req_wstrb    <= mem_wstrb;
            req_wdata    <= mem_wdata;
        end
    end

    // Write commit on the ready edge; reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && mem_ready && req_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    ram[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM; read data is registered on entry to RESP so it reflects pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_rdata <= 32'h0;
            err_count <= 8'h0;
`ifdef BUS_RAM_WAIT_EN
            wait_cnt  <= 4'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid) begin
`ifdef BUS_RAM_WAIT_EN
                        if (WAIT_CYCLES != 0) begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state     <= RESP;
                            mem_rdata <= addr_in_range ? ram[addr_idx] : 32'h0;
                        end
`else
                        state     <= RESP;
                        mem_rdata <= addr_in_range ? ram[addr_idx] : 32'h0;
`endif
                    end
                end
`ifdef BUS_RAM_WAIT_EN
                WAIT: begin
                    if (!mem_valid) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'h0) begin
                        state     <= RESP;
                        mem_rdata <= req_in_range ? ram[req_idx] : 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'h1;
                    end
                end
`endif
                RESP: begin
                    state <= IDLE;
                    if (err && err_count != 8'hFF) begin
                        err_count <= err_count + 8'h1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_ram.sv
// Randomised self-checking bench for bus_ram against an array-based reference model.
// Handles both builds: BUS_RAM_WAIT_EN defined or undefined.
module tb_bus_ram;

    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          WC   = 2;
`ifdef BUS_RAM_WAIT_EN
    localparam int          LAT  = 1 + WC;
`else
    localparam int          LAT  = 1;
`endif

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        err;
    logic [7:0]  err_count;

    bus_ram #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .err      (err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [1 << AW];
    int          model_err;
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        longint lo, hi;
        lo = longint'(BASE);
        hi = lo + 4 * (longint'(1) << AW);
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // One complete transaction; called 1 time unit after a rising edge with the DUT idle.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input bit keep, input bit scramble, output logic [31:0] rd_obs);
        logic [31:0] exp_rd;
        bit          inr;
        bit          got;
        int          c;
        inr    = in_range(a);
        exp_rd = inr ? model[widx(a)] : 32'h0;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        @(negedge clk);
        check("cycle0_ready", {31'h0, mem_ready}, 32'h0);
        c   = 0;
        got = 1'b0;
        while (!got && c < LAT + 4) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 1 && scramble) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_wstrb = 4'($urandom);
            end
            @(negedge clk);
            if (mem_ready) got = 1'b1;
        end
        check("latency", got ? c : -1, LAT);
        rd_obs = mem_rdata;
        check("rdata", mem_rdata, exp_rd);
        check("err", {31'h0, err}, {31'h0, !inr});
        @(posedge clk);
        #1;
        if (got) begin
            if (inr) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) model[widx(a)][8*b +: 8] = wd[8*b +: 8];
            end else if (model_err < 255) begin
                model_err++;
            end
        end
        check("err_count", {24'h0, err_count}, model_err);
        if (!keep) begin
            mem_valid = 1'b0;
            @(negedge clk);
            check("rdata_hold", mem_rdata, exp_rd);
            check("idle_ready", {31'h0, mem_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    // Request withdrawn one cycle after acceptance: nothing may change.
    task automatic abort_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        bit seen;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        @(negedge clk);
        seen = mem_ready;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        check("abort_no_ready", {31'h0, seen}, 32'h0);
        @(posedge clk);
        #1;
        check("abort_err_count", {24'h0, err_count}, model_err);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [3:0]  ws;
        int          sel;

        for (int i = 0; i < (1 << AW); i++) model[i] = 32'h0;
        model_err = 0;
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_err_count", {24'h0, err_count}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full-word write then read back.
        txn(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, rd);
        txn(32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("full_word_readback", rd, 32'hDEAD_BEEF);

        // Single byte-lane update.
        txn(32'h20, 32'h1122_3344, 4'b1111, 1'b0, 1'b0, rd);
        txn(32'h20, 32'h0000_AA00, 4'b0010, 1'b0, 1'b0, rd);
        txn(32'h20, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("byte_lane_merge", rd, 32'h1122_AA44);

        // Withdrawn write leaves memory untouched.
        abort_txn(32'h30, 32'h0000_0055, 4'b1111);
        txn(32'h30, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("abort_old_value", rd, 32'h0);

        // Back-to-back reads with valid held throughout.
        txn(32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, rd);
        txn(32'h4, 32'h0, 4'b0000, 1'b0, 1'b0, rd);

        // Reset in the middle of a write to 0x8.
        mem_valid = 1'b1;
        mem_addr  = 32'h8;
        mem_wdata = 32'hCAFE_F00D;
        mem_wstrb = 4'b1111;
        @(posedge clk);
        #1;
`ifndef BUS_RAM_WAIT_EN
        mem_valid = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", {31'h0, mem_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_valid = 1'b0;
        model_err = 0;
        @(negedge clk);
        check("rst_mid_no_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_mid_rdata", mem_rdata, 32'h0);
        check("rst_mid_err_count", {24'h0, err_count}, 32'h0);
        @(posedge clk);
        #1;
        txn(32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("rst_word8_unchanged", rd, 32'h0);

        // First out-of-range access.
        txn(32'h0000_1000, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("oor_rdata", rd, 32'h0);
        check("oor_err_count_one", {24'h0, err_count}, 32'h1);

        // Randomised mix: in-range with junk low bits, edges of range, wrap candidate, aborts.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            else if (sel == 7) a = 32'h0000_1000 + 32'($urandom_range(0, 255));
            else if (sel == 8) a = 32'hFFFF_FFFC;
            else               a = 32'h0000_0FFC;
            ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 9) == 0)
                abort_txn(a, $urandom, ws);
            else
                txn(a, $urandom, ws, 1'($urandom), 1'($urandom), rd);
        end
        mem_valid = 1'b0;
        @(posedge clk);
        #1;

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++)
            txn(32'h0000_1000, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("err_count_saturated", {24'h0, err_count}, 32'hFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bus_ram.md
BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, meaning log2 of the RAM depth in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h00000000, meaning the byte address of word 0.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before mem_ready when BUS_RAM_WAIT_EN is defined (range 0-15).
REQ-004 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 mem_valid  input  1  initiator request; held high until mem_ready, and may drop early (flush/abort).
REQ-008 mem_ready  output  1  one-cycle completion strobe.
REQ-009 mem_addr  input  32  byte address; bits [1:0] are ignored.
REQ-010 mem_wdata  input  32  write data, lane-aligned.
REQ-011 mem_wstrb  input  4  byte write enables; 4'b0000 means read.
REQ-012 mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-013 err  output  1  high together with mem_ready when the address is out of range.
REQ-014 err_count  output  8  saturating count of out-of-range accesses.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP, and SHALL reset to IDLE.
REQ-016 In IDLE with mem_valid=1, the block SHALL latch the word index, in-range flag, wstrb and wdata; next state is WAIT if the wait feature is enabled and WAIT_CYCLES>0, otherwise RESP.
REQ-017 In WAIT, a 4-bit counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; the FSM SHALL go to RESP when the counter is 0.
REQ-018 On entry to RESP (registered), mem_rdata SHALL take RAM[index], or 32'h0 if the access is out of range.
REQ-019 mem_ready SHALL equal (state==RESP && mem_valid), so it is never high for an aborted request.
REQ-020 In RESP, the FSM SHALL return to IDLE unconditionally; a mem_valid still high in the following IDLE cycle SHALL be treated as a new request.
REQ-021 Latency: with mem_valid first high in cycle 0, mem_ready SHALL be high in cycle 1 (no waits) or in cycle 1+WAIT_CYCLES.
REQ-022 A write SHALL commit only at the clock edge ending a cycle with mem_ready=1, updating only the byte lanes whose wstrb bit is set.
REQ-023 A read in RESP SHALL return pre-write contents, and a write never coincides with a read of the same transaction.
REQ-024 If mem_valid=0 in WAIT or RESP, the block SHALL abort: next state is IDLE, no write, err_count unchanged.
REQ-025 In range means BASE_ADDR <= mem_addr < BASE_ADDR + 4*2^ADDR_WIDTH, evaluated with a 33-bit compare so there is no wrap-around at 32'hFFFFFFFC.
REQ-026 For an out-of-range access, mem_ready SHALL be given with normal latency, err=1, writes discarded, and err_count incremented on the ready edge, saturating at 8'hFF.
REQ-027 mem_rdata SHALL hold its last value outside RESP.
REQ-028 A changed mem_addr or mem_wstrb during WAIT SHALL be ignored; the latched values are used.

Reset
REQ-029 Reset SHALL force state=IDLE, counter=0, mem_ready=0, err=0, mem_rdata=32'h0 and err_count=8'h0.
REQ-030 Reset mid-transaction SHALL drop the pending write, and no mem_ready SHALL follow.
REQ-031 RAM contents SHALL NOT be cleared by reset; the array SHALL be initialised to zero at time 0.

Configuration
REQ-032 Macro BUS_RAM_WAIT_EN defined SHALL enable the WAIT state and counter, giving WAIT_CYCLES wait states.
REQ-033 Macro BUS_RAM_WAIT_EN undefined SHALL compile out WAIT and the counter, ignore WAIT_CYCLES, and give fixed 1-cycle latency.

Verification
REQ-034 Write 0xDEADBEEF to 0x10 with wstrb 4'b1111, then read 0x10 -> mem_rdata=0xDEADBEEF with mem_ready; latency is 1 cycle (macro off) or 3 cycles (macro on, WAIT_CYCLES=2).
REQ-035 Word 0x20=0x11223344, write 0x0000AA00 with wstrb 4'b0010, then read -> 0x1122AA44.
REQ-036 mem_valid drops in WAIT during a write of 0x55 to 0x30 -> no mem_ready, and a later read of 0x30 returns the old value 0.
REQ-037 Read of 0x00001000 (ADDR_WIDTH=10, BASE 0) -> mem_ready with err=1, mem_rdata=0, err_count=1; after 300 such reads err_count=0xFF.
REQ-038 Back-to-back reads of 0x0 and 0x4 with mem_valid held continuously -> two separate mem_ready pulses, with one IDLE cycle between them.
REQ-039 rst asserted in WAIT during a write to 0x8 -> state IDLE, no mem_ready, and word 0x8 is unchanged.
